sar_adc_ctrl: RTL
=================

Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller for the mixed-signal ADC symbol. It is the read-back direction of the analog source mapping: it drives a DAC code into the analog netlist, reads a 1-bit comparator back, and builds a WIDTH-bit conversion result. It sits between the analog DAC/comparator/track-hold devices and the digital section.

Parameters:
WIDTH, 8, result and DAC code width in bits; must be at least 2.
SAMPLE_CYCLES, 2, cycles that sample stays high (track phase); must be at least 1.
SETTLE, 2, cycles each trial code is held before cmp is evaluated; must be at least 1.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  synchronous reset, active-low.
start  input  1  request a conversion; accepted only in IDLE.
abort  input  1  cancel an in-flight conversion.
cmp  input  1  comparator output; 1 means vin > vdac.
sample  output  1  track/hold control; 1 means track.
dac_code  output  WIDTH  trial code driven to the DAC.
busy  output  1  high from the cycle after start is accepted until DONE is left.
done  output  1  single-cycle pulse; result is valid in the same cycle.
result  output  WIDTH  last completed conversion; holds its value until the next done.

Behaviour:
- Interface fact: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state IDLE. sample=0, dac_code=0, busy=0, done=0, result=0, and all counters are cleared.
- Reset mid-conversion is identical to reset from IDLE. No done is produced.
- States are IDLE, SAMPLE, CONVERT, DONE.
- IDLE: all outputs hold their reset values except result.
  - start=1 at an edge moves to SAMPLE.
  - The start cycle is cycle 0.
- SAMPLE: occupies cycles 1..SAMPLE_CYCLES.
  - sample=1, busy=1, dac_code=0.
  - After SAMPLE_CYCLES cycles, moves to CONVERT with bit index i=WIDTH-1.
- CONVERT: bits are decided MSB first.
  - For bit i, dac_code = accumulated code with bit i set; bits below i are 0.
  - The trial code is held for SETTLE cycles; sample=0, busy=1.
  - On the last settle cycle, cmp is registered:
    - cmp=1: keep bit i.
    - cmp=0: clear bit i.
  - i then decrements. After bit 0 is decided, the state moves to DONE.
  - dac_code changes only at bit boundaries.
- DONE: lasts exactly one cycle, cycle 1+SAMPLE_CYCLES+WIDTH*SETTLE.
  - done=1, busy=1, dac_code=0, result=final code.
  - Next state is IDLE.
  - start during DONE is ignored; back-to-back conversions need start asserted in IDLE.
- Latency: done is asserted SAMPLE_CYCLES+WIDTH*SETTLE+1 cycles after the start edge. With defaults, done is in cycle 19.
- start while not in IDLE is ignored.
- abort=1 in SAMPLE or CONVERT: next state IDLE, busy=0, dac_code=0, sample=0, no done, result unchanged.
  - abort in IDLE or DONE has no effect; DONE still completes.
- Simultaneous events:
  - rst_n=0 has priority over abort.
  - abort has priority over the normal transition.
  - start and abort together in IDLE: the conversion starts.
- Counters:
  - The settle counter is wide enough for SETTLE-1 and wraps to 0 at each bit boundary.
  - The sample counter is wide enough for SAMPLE_CYCLES-1.
  - The bit index is $clog2(WIDTH) bits wide; no underflow past 0.
- cmp is sampled only on settle-final cycles. cmp in all other cycles is don't-care and must not affect state.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Bench model is cmp = (VIN >= dac_code), which yields result = VIN.
- Defaults, VIN=0xA5, start pulse: sample high in cycles 1-2; dac_code sequence 0x80,0x80,0xC0,0xC0,0xA0,...; done in cycle 19 only; result=0xA5; busy low in cycle 20.
- Range edges: VIN=0xFF gives result=0xFF with every trial bit kept; VIN=0x00 gives result=0x00 with trial codes 0x80,0x40,...,0x01 all rejected.
- start re-asserted in cycles 1-19 and in the DONE cycle: exactly one done; the next start, taken in IDLE at cycle 21, produces done at cycle 40.
- abort in cycle 10 with previous result=0x5A: busy=0 and dac_code=0 from cycle 11; no done over 30 cycles; result stays 0x5A.
- rst_n=0 in cycle 8 mid-conversion: all outputs at reset values the next cycle, result=0x00, no done; a new start then completes normally.
- WIDTH=4, SAMPLE_CYCLES=1, SETTLE=1, VIN=0x9: done in cycle 6 and result=0x9. With cmp toggled randomly off the settle-final cycles, the result is unchanged.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: tracks the input, then walks a trial code
// MSB first against the comparator and publishes the WIDTH-bit conversion result.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int TCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int IW  = $clog2(WIDTH);

  localparam logic [SCW-1:0]   SAMPLE_LAST = SCW'(SAMPLE_CYCLES - 1);
  localparam logic [TCW-1:0]   SETTLE_LAST = TCW'(SETTLE - 1);
  localparam logic [IW-1:0]    MSB_IDX     = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_MASK    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [SCW-1:0]   r_sampleCnt;
  logic [TCW-1:0]   r_settleCnt;
  logic [IW-1:0]    r_bitIdx;
  logic             r_sample;
  logic [WIDTH-1:0] r_dacCode;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  state_t           w_stateNext;
  logic [SCW-1:0]   w_sampleCntNext;
  logic [TCW-1:0]   w_settleCntNext;
  logic [IW-1:0]    w_bitIdxNext;
  logic             w_sampleNext;
  logic [WIDTH-1:0] w_dacCodeNext;
  logic             w_busyNext;
  logic             w_doneNext;
  logic [WIDTH-1:0] w_resultNext;
  logic [WIDTH-1:0] w_bitMask;
  logic [WIDTH-1:0] w_decided;

  // During CONVERT the DAC register doubles as the accumulator, so the decided code
  // is the current trial with bit i kept or dropped according to the comparator.
  assign w_bitMask = WIDTH'(1) << r_bitIdx;
  assign w_decided = cmp ? r_dacCode : (r_dacCode & ~w_bitMask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sampleCnt <= '0;
      r_settleCnt <= '0;
      r_bitIdx    <= '0;
      r_sample    <= 1'b0;
      r_dacCode   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_sampleCnt <= w_sampleCntNext;
      r_settleCnt <= w_settleCntNext;
      r_bitIdx    <= w_bitIdxNext;
      r_sample    <= w_sampleNext;
      r_dacCode   <= w_dacCodeNext;
      r_busy      <= w_busyNext;
      r_done      <= w_doneNext;
      r_result    <= w_resultNext;
    end
  end

  // Outputs are computed for the next state and registered alongside it, so every
  // output lines up with the state it belongs to without an input-to-output path.
  always_comb begin
    w_stateNext     = r_state;
    w_sampleCntNext = r_sampleCnt;
    w_settleCntNext = r_settleCnt;
    w_bitIdxNext    = r_bitIdx;
    w_sampleNext    = 1'b0;
    w_dacCodeNext   = '0;
    w_busyNext      = 1'b0;
    w_doneNext      = 1'b0;
    w_resultNext    = r_result;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_stateNext     = ST_SAMPLE;
          w_sampleCntNext = '0;
          w_sampleNext    = 1'b1;
          w_busyNext      = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          w_stateNext     = ST_IDLE;
          w_sampleCntNext = '0;
        end else if (r_sampleCnt == SAMPLE_LAST) begin
          w_stateNext     = ST_CONVERT;
          w_sampleCntNext = '0;
          w_settleCntNext = '0;
          w_bitIdxNext    = MSB_IDX;
          w_dacCodeNext   = MSB_MASK;
          w_busyNext      = 1'b1;
        end else begin
          w_sampleCntNext = r_sampleCnt + SCW'(1);
          w_sampleNext    = 1'b1;
          w_busyNext      = 1'b1;
        end
      end

      ST_CONVERT: begin
        if (abort) begin
          w_stateNext     = ST_IDLE;
          w_settleCntNext = '0;
          w_bitIdxNext    = '0;
        end else if (r_settleCnt == SETTLE_LAST) begin
          w_settleCntNext = '0;
          w_busyNext      = 1'b1;
          if (r_bitIdx == '0) begin
            w_stateNext  = ST_DONE;
            w_doneNext   = 1'b1;
            w_resultNext = w_decided;
          end else begin
            w_bitIdxNext  = r_bitIdx - IW'(1);
            w_dacCodeNext = w_decided | (w_bitMask >> 1);
          end
        end else begin
          w_settleCntNext = r_settleCnt + TCW'(1);
          w_dacCodeNext   = r_dacCode;
          w_busyNext      = 1'b1;
        end
      end

      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign sample   = r_sample;
  assign dac_code = r_dacCode;
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;

endmodule
